hilo_ctrl: RTL

Multi-cycle sequencer for the HI/LO multiply/divide resource of the MIPS core. Accepts mult/multu/div/divu issues from the control path, runs a 32-iteration shift-add multiply or restoring divide, and owns the HI and LO registers. Services mthi/mtlo/mfhi/mflo and produces the pipeline stall interlock. Honours exception cancellation so a trapped instruction never commits HI/LO.

---
 rtl/hilo_pkg.sv | 13 +
 rtl/hilo_step.sv | 34 +++
 rtl/hilo_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared constants and types for the HI/LO multiply/divide sequencer.
package hilo_pkg;
  localparam int HILO_WIDTH = 32;
  localparam int HILO_ITER  = 32;
  localparam int CNT_W      = 5;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/hilo_step.sv
// One combinational iteration of shift-add multiply or restoring divide
// on a {upper, lower} double-width accumulator.
module hilo_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qbit
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_trial;

  // The carry of the multiply add lands in the top bit after the shift.
  assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
  assign w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_trial  = w_rem_sh - {1'b0, i_opnd};

  always_comb begin
    o_acc  = '0;
    o_qbit = 1'b0;
    if (i_div) begin
      o_qbit                 = ~w_trial[WIDTH];
      o_acc[WIDTH-1:0]       = {i_acc[WIDTH-2:0], 1'b0};
      o_acc[2*WIDTH-1:WIDTH] = o_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: issue acceptance, 32-step iteration, sign fix, HI/LO
// ownership, mthi/mtlo service and the pipeline stall interlock.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH,
  parameter int ITER  = HILO_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mf_req,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_signed;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  // Signed ops run on magnitudes; 0x80000000 stays 0x80000000 as unsigned.
  assign w_signed = ~op[0];
  assign w_mag_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  hilo_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_div),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!cancel && start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_div   <= op[1];
            r_opnd  <= op[1] ? w_mag_b : w_mag_a;
            r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
            r_neg_q <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= w_signed & a[WIDTH-1];
          end else if (!cancel) begin
            if (mt_hi) r_hi <= mt_data;
            if (mt_lo) r_lo <= mt_data;
          end
        end
        RUN: begin
          if (cancel) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc_nxt | {{(2*WIDTH-1){1'b0}}, w_qbit};
            if (r_cnt == CNT_LAST) begin
              r_state <= FIX;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= '0;
          // A flush landing on the FIX cycle must leave HI/LO untouched.
          if (!cancel) begin
            r_hi <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
            r_lo <= r_div ? w_quo : w_prod[WIDTH-1:0];
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign stall = r_busy & (start | mt_hi | mt_lo | mf_req);
  assign hi    = r_hi;
  assign lo    = r_lo;
endmodule
